// File: rtl/lcd_trace_pkg.sv
// Shared types and helpers for the LCD trace capture engine.
package lcd_trace_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Address width for a power-of-two trace depth.
   function automatic int unsigned calc_aw(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Pre-trigger window can never exceed the buffer minus the trigger sample.
   function automatic int unsigned clamp_pretrig(input int unsigned pretrig,
                                                 input int unsigned depth);
      return (pretrig > depth - 1) ? depth - 1 : pretrig;
   endfunction

endpackage

// File: rtl/lcd_trace_buffer_if.sv
// Control, probe and readout bundle between the trace engine and its host.
interface lcd_trace_buffer_if #(
   parameter int unsigned DATA_W = 17,
   parameter int unsigned AW     = 10,
   parameter int unsigned DIV_W  = 8
);
   logic [DATA_W-1:0] sample_data;
   logic              arm;
   logic              abort;
   logic              force_trig;
   logic [DATA_W-1:0] trig_mask;
   logic [DATA_W-1:0] trig_value;
   logic              trig_edge;
   logic [AW-1:0]     pretrig;
   logic [DIV_W-1:0]  decim;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              triggered;
   logic              done;

   modport master (
      output sample_data, arm, abort, force_trig, trig_mask, trig_value,
             trig_edge, pretrig, decim, rd_addr,
      input  rd_data, busy, triggered, done
   );

   modport slave (
      input  sample_data, arm, abort, force_trig, trig_mask, trig_value,
             trig_edge, pretrig, decim, rd_addr,
      output rd_data, busy, triggered, done
   );
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port sample store with registered read port.
module trace_ram #(
   parameter int unsigned DATA_W = 17,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned AW     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Output register carries the reset so the array itself stays pure block RAM.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/lcd_trace_buffer.sv
// Trace capture engine: pre-trigger window, masked level/edge trigger,
// decimated sampling into a circular buffer, trigger-relative readout.
module lcd_trace_buffer
   import lcd_trace_pkg::*;
#(
   parameter int unsigned DATA_W = 17,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned DIV_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   lcd_trace_buffer_if.slave   bus
);

   localparam int unsigned AW = calc_aw(DEPTH);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     pretrig_q, pretrig_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic              edge_q, edge_d;
   logic [DIV_W-1:0]  decim_q, decim_d;
   logic              prev_cond_q, prev_cond_d;
   logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
   logic              triggered_q, triggered_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              in_capture_c;
   logic              tick_c;
   logic              cond_c;
   logic              hit_c;
   logic              we_c;
   logic [AW-1:0]     pretrig_in_c;
   logic [AW-1:0]     post_len_c;
   logic [AW-1:0]     rd_phys_c;
   logic [DATA_W-1:0] rd_data_c;

   assign pretrig_in_c = AW'(clamp_pretrig(32'(bus.pretrig), DEPTH));
   assign post_len_c   = AW'(DEPTH - 1) - pretrig_q;

   // Logical index 0 is the oldest kept sample; index pretrig is the trigger.
   assign rd_phys_c = trig_ptr_q - pretrig_q + bus.rd_addr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         pretrig_q   <= '0;
         mask_q      <= '0;
         value_q     <= '0;
         edge_q      <= 1'b0;
         decim_q     <= '0;
         prev_cond_q <= 1'b0;
         trig_ptr_q  <= '0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         pretrig_q   <= pretrig_d;
         mask_q      <= mask_d;
         value_q     <= value_d;
         edge_q      <= edge_d;
         decim_q     <= decim_d;
         prev_cond_q <= prev_cond_d;
         trig_ptr_q  <= trig_ptr_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      pretrig_d   = pretrig_q;
      mask_d      = mask_q;
      value_d     = value_q;
      edge_d      = edge_q;
      decim_d     = decim_q;
      prev_cond_d = prev_cond_q;
      trig_ptr_d  = trig_ptr_q;
      triggered_d = triggered_q;
      done_d      = done_q;
      we_c        = 1'b0;

      in_capture_c = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
      tick_c       = in_capture_c && (div_q == '0);
      cond_c       = (((bus.sample_data ^ value_q) & mask_q) == '0);
      hit_c        = bus.force_trig || (edge_q ? (cond_c && !prev_cond_q) : cond_c);

      if (in_capture_c) begin
         div_d = tick_c ? decim_q : div_q - DIV_W'(1);
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.arm) begin
               wr_ptr_d    = '0;
               cnt_d       = '0;
               div_d       = '0;
               pretrig_d   = pretrig_in_c;
               mask_d      = bus.trig_mask;
               value_d     = bus.trig_value;
               edge_d      = bus.trig_edge;
               decim_d     = bus.decim;
               prev_cond_d = 1'b0;
               triggered_d = 1'b0;
               done_d      = 1'b0;
               state_d     = (pretrig_in_c == '0) ? ST_ARMED : ST_PRE;
            end
         end
         ST_PRE: begin
            // Condition history is tracked here so edges can span the PRE/ARMED boundary.
            if (tick_c) begin
               we_c        = 1'b1;
               wr_ptr_d    = wr_ptr_q + AW'(1);
               cnt_d       = cnt_q + AW'(1);
               prev_cond_d = cond_c;
               if (cnt_q + AW'(1) == pretrig_q) begin
                  state_d = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (tick_c) begin
               we_c        = 1'b1;
               wr_ptr_d    = wr_ptr_q + AW'(1);
               prev_cond_d = cond_c;
               if (hit_c) begin
                  trig_ptr_d  = wr_ptr_q;
                  triggered_d = 1'b1;
                  cnt_d       = '0;
                  if (post_len_c == '0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_POST;
                  end
               end
            end
         end
         ST_POST: begin
            if (tick_c) begin
               we_c     = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               cnt_d    = cnt_q + AW'(1);
               if (cnt_q + AW'(1) == post_len_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over everything, including an arm in the same cycle.
      if (bus.abort) begin
         state_d     = ST_IDLE;
         we_c        = 1'b0;
         triggered_d = 1'b0;
         done_d      = 1'b0;
      end

      busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
   end

   trace_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we_c),
      .waddr (wr_ptr_q),
      .wdata (bus.sample_data),
      .raddr (rd_phys_c),
      .rdata (rd_data_c)
   );

   assign bus.rd_data   = rd_data_c;
   assign bus.busy      = busy_q;
   assign bus.triggered = triggered_q;
   assign bus.done      = done_q;

endmodule

// File: doc/lcd_trace_buffer.md
# lcd_trace_buffer

Parametrised on-chip trace capture engine for LCD hardware bring-up. It succeeds the fixed-width, externally cored logic-analyser capture path with a synthesizable, self-contained block: configurable sample width and depth, pre-trigger window, masked level/edge trigger, decimation, and random-access readout. It sits beside `lcd_controller` in the hardware test top, sampling its pins and handshake, with control driven by the VIO (virtual I/O) or a host register interface.

## Interface
Parameters:
- `DATA_W`, 17: sample width in bits.
- `DEPTH`, 1024: trace depth in samples. Must be a power of two, at least 4. `AW = log2(DEPTH)`.
- `DIV_W`, 8: width of the decimation divider.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `sample_data`  in  DATA_W: probe vector, e.g. {e, nibble, rs, rw, disable_flash, done, strobe}.
- `arm`  in  1: single-cycle pulse that starts a capture.
- `abort`  in  1: returns the block to IDLE from any state.
- `force_trig`  in  1: unconditional trigger, honoured in ARMED only.
- `trig_mask`  in  DATA_W: bits that take part in the compare.
- `trig_value`  in  DATA_W: compare value.
- `trig_edge`  in  1: 0 selects level trigger, 1 selects rising-condition trigger.
- `pretrig`  in  AW: samples kept before the trigger. Clamped to DEPTH-1.
- `decim`  in  DIV_W: take one sample every decim+1 clocks.
- `rd_addr`  in  AW: logical read index; 0 is the oldest sample.
- `rd_data`  out  DATA_W: read data, registered.
- `busy`  out  1: high in PRE, ARMED and POST.
- `triggered`  out  1: high from the trigger sample until the next arm or abort.
- `done`  out  1: capture complete; buffer is readable.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- Sample tick:
  - A divider counts down from `decim`. A tick fires when it reaches 0, then the divider reloads.
  - `arm` loads 0, so the first tick is the cycle after arm.
  - Writes and trigger evaluation happen only on ticks.
- IDLE/DONE + `arm`:
  - Clear the write pointer and sample count.
  - Latch `pretrig` (clamped), `trig_mask`, `trig_value`, `trig_edge` and `decim`.
  - Clear `done` and `triggered`; go to PRE.
- `arm` while busy is ignored.
- PRE:
  - Write every tick and count.
  - When count == latched pretrig, go to ARMED. With pretrig=0, go to ARMED at once.
  - The trigger is not evaluated in PRE.
- ARMED:
  - Write every tick, wrapping circularly.
  - Trigger condition: `force_trig`, or `cond` in level mode, or (`cond` and not `prev_cond`) in edge mode.
  - `cond` = ((sample_data ^ trig_value) & trig_mask) == 0.
  - `prev_cond` is `cond` at the previous tick. It is cleared on arm, so an edge needs a false→true seen inside ARMED or PRE.
  - On trigger: the triggering sample is written, `trig_ptr` <= write address, `triggered`=1, go to POST.
- POST: write until DEPTH-1-pretrig further samples are stored, then go to DONE with `done`=1. With pretrig=DEPTH-1, go from trigger straight to DONE.
- Readout: physical address = (trig_ptr - pretrig + rd_addr) mod DEPTH. Logical index `pretrig` is the trigger sample.
- Readout is valid whenever `done` is high. Reads in other states return undefined data.
- `abort`:
  - Takes priority over `arm` in the same cycle.
  - Goes to IDLE and clears `done` and `triggered`.
  - Buffer contents are retained but not valid.
- Reset mid-capture behaves like abort, and also zeroes `rd_data`.

## Timing
- Reset values: `rd_data`=0, `busy`=0, `triggered`=0, `done`=0; state IDLE.
- Arm at cycle n: `busy`=1 at n+1, and the first write is at n+1.
- Trigger tick at cycle t: `triggered`=1 at t+1.
- Last POST write at cycle w: `done`=1 and `busy`=0 at w+1.
- Read latency is 1 clock: `rd_addr` at cycle k gives `rd_data` at k+1.
- Pointer arithmetic is AW-bit unsigned, with natural wrap.
- A trigger on the same tick that PRE completes is not taken. Trigger evaluation starts at the first ARMED tick.

## Structure
- Package `lcd_trace_pkg` holds:
  - the state enum;
  - a function that clamps pretrig;
  - the `AW` derivation.
- Sub-module `trace_ram`: simple dual-port RAM with synchronous read, DATA_W×DEPTH, inferred to block RAM.
- Control FSM, divider and trigger logic live in `lcd_trace_buffer`.

## Test plan
All scenarios use DEPTH=16, DATA_W=17.
- Ramp with level trigger:
  - Setup: sample_data = cycle counter, decim=0, pretrig=4, mask=all-ones, value=20, arm at cycle 0.
  - Result: `done` rises; reading 0..15 gives 16..31; index 4 = 20.
- Edge trigger: mask=1 on bit 0, value=1, trig_edge=1, input held at 1 from arm. No trigger until the input drops to 0 and returns to 1; the trigger sample is the first 1 after the 0.
- Decimation: decim=2, ramp input. Stored samples differ by 3, and the first stored value is the value at arm+1.
- force_trig with mask=0:
  - Level mode with mask=0 triggers on the first ARMED tick.
  - force_trig pulsed in PRE is ignored.
  - pretrig=0 gives the trigger sample at index 0.
- Abort and re-arm: abort mid-POST gives busy=0, triggered=0, done=0 the next cycle. An arm in the same cycle as abort is ignored; a later re-arm completes normally.
- Boundaries:
  - pretrig=15: `done` rises the cycle after the trigger.
  - pretrig input 31 (AW=4 truncation aside) or a clamp check via a width-extended test.
  - A reset pulse mid-ARMED zeroes every output.
